// File: rtl/traffic_ctrl_param.sv
// ----------------------------------------------------------------------------
// traffic_ctrl_param
//   Parametrised four-approach traffic-light controller: two main through
//   lanes (M1, M2), the main turn lane (MT) and a side road (S). Phases are
//   timed by a dwell counter that advances only on prescaler ticks. The side
//   phase is skipped when no side vehicle is pending, and a level-sensitive
//   flash request puts the junction into blinking maintenance mode. Leaving
//   maintenance mode passes through an all-red recovery interval.
//
// Ports
//   clk       in   single clock, all state changes on posedge
//   reset     in   synchronous active-high reset
//   tick      in   one-cycle advance enable from the 1 Hz prescaler
//   side_req  in   side-road vehicle sensor, sampled every cycle
//   flash     in   maintenance mode request, level sensitive
//   M1/M2/MT/S out lamp codes {R,Y,G}: 100 red, 010 yellow, 001 green, 000 dark
//   phase     out  current state encoding (0..7)
//   count     out  current dwell count
// ----------------------------------------------------------------------------
module traffic_ctrl_param #(
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned T_MAIN   = 7,
    parameter int unsigned T_TURN   = 5,
    parameter int unsigned T_SIDE   = 3,
    parameter int unsigned T_YEL    = 2,
    parameter int unsigned T_ALLRED = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             side_req,
    input  logic             flash,
    output logic [2:0]       M1,
    output logic [2:0]       M2,
    output logic [2:0]       MT,
    output logic [2:0]       S,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] count
);

    // Largest terminal count, used to validate CNT_W at elaboration.
    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned T_MAX = max2(max2(max2(T_MAIN, T_TURN), max2(T_SIDE, T_YEL)), T_ALLRED);

    if (64'(T_MAX) > ((64'(1) << CNT_W) - 64'(1))) begin : g_cnt_w_check
        $error("traffic_ctrl_param: CNT_W=%0d cannot hold terminal count %0d", CNT_W, T_MAX);
    end

    // Lamp codes {R,Y,G}.
    localparam logic [2:0] LAMP_RED  = 3'b100;
    localparam logic [2:0] LAMP_YEL  = 3'b010;
    localparam logic [2:0] LAMP_GRN  = 3'b001;
    localparam logic [2:0] LAMP_DARK = 3'b000;

    typedef enum logic [2:0] {
        ST_MAIN_GO  = 3'd0,
        ST_M2_YEL   = 3'd1,
        ST_TURN_GO  = 3'd2,
        ST_M1_YEL   = 3'd3,
        ST_SIDE_GO  = 3'd4,
        ST_SIDE_YEL = 3'd5,
        ST_ALL_RED  = 3'd6,
        ST_FLASH    = 3'd7
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             side_pend_q;
    logic             side_pend_d;
    logic             blink_q;
    logic             blink_d;

    logic [CNT_W-1:0] t_cur;
    logic             at_term;
    logic             side_go;

    // State register: state, dwell counter, pending side request, blink phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_MAIN_GO;
            count_q     <= '0;
            side_pend_q <= 1'b0;
            blink_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            side_pend_q <= side_pend_d;
            blink_q     <= blink_d;
        end
    end

    // Terminal dwell count of the current state; FLASH is untimed.
    always_comb begin
        t_cur = '0;
        case (state_q)
            ST_MAIN_GO:  t_cur = CNT_W'(T_MAIN);
            ST_M2_YEL:   t_cur = CNT_W'(T_YEL);
            ST_TURN_GO:  t_cur = CNT_W'(T_TURN);
            ST_M1_YEL:   t_cur = CNT_W'(T_YEL);
            ST_SIDE_GO:  t_cur = CNT_W'(T_SIDE);
            ST_SIDE_YEL: t_cur = CNT_W'(T_YEL);
            ST_ALL_RED:  t_cur = CNT_W'(T_ALLRED);
            default:     t_cur = '0;
        endcase
    end

    assign at_term = (count_q == t_cur);
    // A request arriving on the deciding tick still counts toward the decision.
    assign side_go = side_pend_q | side_req;

    // Next-state logic: flash override first, then tick-gated dwell/advance.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        blink_d     = blink_q;
        side_pend_d = side_pend_q | side_req;

        if (flash) begin
            state_d = ST_FLASH;
            count_d = '0;
            if (state_q != ST_FLASH) begin
                blink_d = 1'b1;
            end else if (tick) begin
                blink_d = ~blink_q;
            end
        end else if (state_q == ST_FLASH) begin
            state_d = ST_ALL_RED;
            count_d = '0;
        end else if (tick) begin
            if (at_term) begin
                count_d = '0;
                case (state_q)
                    ST_MAIN_GO:  state_d = ST_M2_YEL;
                    ST_M2_YEL:   state_d = ST_TURN_GO;
                    ST_TURN_GO:  state_d = ST_M1_YEL;
                    ST_M1_YEL:   state_d = side_go ? ST_SIDE_GO : ST_MAIN_GO;
                    ST_SIDE_GO:  state_d = ST_SIDE_YEL;
                    ST_SIDE_YEL: state_d = ST_MAIN_GO;
                    ST_ALL_RED:  state_d = ST_MAIN_GO;
                    default:     state_d = ST_MAIN_GO;
                endcase
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end

        // Serving the side road consumes the request; clear beats a new request.
        if ((state_d == ST_SIDE_GO) && (state_q != ST_SIDE_GO)) begin
            side_pend_d = 1'b0;
        end
    end

    // Moore output decode of the registered state.
    always_comb begin
        M1    = LAMP_RED;
        M2    = LAMP_RED;
        MT    = LAMP_RED;
        S     = LAMP_RED;
        phase = state_q;
        count = count_q;
        case (state_q)
            ST_MAIN_GO: begin
                M1 = LAMP_GRN;
                M2 = LAMP_GRN;
            end
            ST_M2_YEL: begin
                M1 = LAMP_GRN;
                M2 = LAMP_YEL;
            end
            ST_TURN_GO: begin
                M1 = LAMP_GRN;
                MT = LAMP_GRN;
            end
            ST_M1_YEL: begin
                M1 = LAMP_YEL;
                MT = LAMP_YEL;
            end
            ST_SIDE_GO: begin
                S = LAMP_GRN;
            end
            ST_SIDE_YEL: begin
                S = LAMP_YEL;
            end
            ST_ALL_RED: begin
                M1 = LAMP_RED;
            end
            ST_FLASH: begin
                // Main approaches blink amber, side road blinks red.
                M1 = blink_q ? LAMP_YEL : LAMP_DARK;
                M2 = blink_q ? LAMP_YEL : LAMP_DARK;
                MT = blink_q ? LAMP_YEL : LAMP_DARK;
                S  = blink_q ? LAMP_RED : LAMP_DARK;
            end
            default: begin
                M1 = LAMP_RED;
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// ----------------------------------------------------------------------------
// tb_traffic_ctrl_param
//   Directed self-checking bench for traffic_ctrl_param with default
//   parameters. Inputs are driven and outputs sampled 1 time unit after each
//   rising edge; expected phases, counts and lamps are hand-derived.
// ----------------------------------------------------------------------------
module tb_traffic_ctrl_param;

    localparam int unsigned CNT_W    = 4;
    localparam int unsigned T_MAIN   = 7;
    localparam int unsigned T_TURN   = 5;
    localparam int unsigned T_SIDE   = 3;
    localparam int unsigned T_YEL    = 2;
    localparam int unsigned T_ALLRED = 2;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] D = 3'b000;

    logic             clk = 1'b0;
    logic             reset;
    logic             tick;
    logic             side_req;
    logic             flash;
    logic [2:0]       M1;
    logic [2:0]       M2;
    logic [2:0]       MT;
    logic [2:0]       S;
    logic [2:0]       phase;
    logic [CNT_W-1:0] count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    traffic_ctrl_param #(
        .CNT_W    (CNT_W),
        .T_MAIN   (T_MAIN),
        .T_TURN   (T_TURN),
        .T_SIDE   (T_SIDE),
        .T_YEL    (T_YEL),
        .T_ALLRED (T_ALLRED)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .side_req (side_req),
        .flash    (flash),
        .M1       (M1),
        .M2       (M2),
        .MT       (MT),
        .S        (S),
        .phase    (phase),
        .count    (count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected lamps {M1,M2,MT,S} for each timed state.
    function automatic logic [11:0] lamps_of(input int ph);
        case (ph)
            0:       return {G, G, R, R};
            1:       return {G, Y, R, R};
            2:       return {G, R, G, R};
            3:       return {Y, R, Y, R};
            4:       return {R, R, R, G};
            5:       return {R, R, R, Y};
            6:       return {R, R, R, R};
            default: return 12'h000;
        endcase
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_lamps(input string tag, input logic [11:0] exp);
        check(tag, 32'({M1, M2, MT, S}), 32'(exp));
    endtask

    // Expect a whole state from count 0 to terminal t; tick every tdiv clocks,
    // side_req pulsed on the ticking clock of count req_at (-1 for none).
    task automatic phase_run(input string tag, input int ph, input int t,
                             input int req_at, input int tdiv);
        for (int i = 0; i <= t; i++) begin
            for (int k = 0; k < tdiv; k++) begin
                if (i == 0 && k == 0) check_lamps({tag, "_lamps"}, lamps_of(ph));
                check({tag, "_phase"}, 32'(phase), 32'(ph));
                check({tag, "_count"}, 32'(count), 32'(i));
                tick     = (k == tdiv - 1);
                side_req = (i == req_at) && (k == tdiv - 1);
                cycle();
            end
        end
        side_req = 1'b0;
    endtask

    task automatic main_round(input string tag, input int req0, input int req3, input int tdiv);
        phase_run({tag, "_p0"}, 0, T_MAIN, req0, tdiv);
        phase_run({tag, "_p1"}, 1, T_YEL,  -1,   tdiv);
        phase_run({tag, "_p2"}, 2, T_TURN, -1,   tdiv);
        phase_run({tag, "_p3"}, 3, T_YEL,  req3, tdiv);
    endtask

    task automatic side_round(input string tag, input int req5);
        phase_run({tag, "_p4"}, 4, T_SIDE, -1,   1);
        phase_run({tag, "_p5"}, 5, T_YEL,  req5, 1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_phase"}, 32'(phase), 32'd0);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_m1"},    32'(M1),    32'(G));
        check({tag, "_m2"},    32'(M2),    32'(G));
        check({tag, "_mt"},    32'(MT),    32'(R));
        check({tag, "_s"},     32'(S),     32'(R));
    endtask

    initial begin
        reset    = 1'b1;
        tick     = 1'b0;
        side_req = 1'b0;
        flash    = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;
        check_reset_state("rst");

        // Full round with a side request pulsed in P0, then a skipped round.
        tick = 1'b1;
        main_round("r1", 0, -1, 1);
        side_round("r1", -1);
        main_round("r2", -1, -1, 1);
        main_round("r3", -1, -1, 1);

        // Slow ticks: every dwell is four times longer.
        main_round("slow", -1, -1, 4);

        // tick low holds count mid-phase.
        tick = 1'b1;
        cycle();
        cycle();
        tick = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("hold_phase", 32'(phase), 32'd0);
            check("hold_count", 32'(count), 32'd2);
        end
        tick = 1'b1;
        for (int i = 2; i <= int'(T_MAIN); i++) begin
            check("resume_count", 32'(count), 32'(i));
            cycle();
        end
        phase_run("fl_p1", 1, T_YEL, -1, 1);

        // Flash raised in P2 at count 3, with a side request left pending.
        for (int i = 0; i < 3; i++) begin
            check("fl_p2_phase", 32'(phase), 32'd2);
            check("fl_p2_count", 32'(count), 32'(i));
            side_req = (i == 0);
            cycle();
        end
        side_req = 1'b0;
        check("fl_pre_count", 32'(count), 32'd3);
        flash = 1'b1;
        cycle();
        check("fl_phase", 32'(phase), 32'd7);
        check("fl_count", 32'(count), 32'd0);
        check_lamps("fl_lit1", {Y, Y, Y, R});
        cycle();
        check_lamps("fl_dark1", {D, D, D, D});
        cycle();
        check_lamps("fl_lit2", {Y, Y, Y, R});
        tick = 1'b0;
        cycle();
        cycle();
        cycle();
        check_lamps("fl_hold", {Y, Y, Y, R});
        check("fl_hold_phase", 32'(phase), 32'd7);
        tick = 1'b1;
        cycle();
        check_lamps("fl_dark2", {D, D, D, D});
        flash = 1'b0;
        cycle();
        phase_run("allred", 6, T_ALLRED, -1, 1);
        // Side request from before the flash is still served.
        main_round("post_fl", -1, -1, 1);
        side_round("post_fl", -1);

        // Request on P3 terminal tick: decides for P4, then cleared on entry.
        main_round("entry", -1, int'(T_YEL), 1);
        side_round("entry", -1);
        main_round("entry_skip", -1, -1, 1);
        check("entry_skip_p0", 32'(phase), 32'd0);

        // Request during P5 is served in the following round.
        main_round("p5req", 0, -1, 1);
        side_round("p5req", 1);
        main_round("p5req_next", -1, -1, 1);
        side_round("p5req_next", -1);

        // Reset in P4 with a fresh request pending.
        main_round("rst4", 0, -1, 1);
        check("rst4_at_p4", 32'(phase), 32'd4);
        side_req = 1'b1;
        cycle();
        side_req = 1'b0;
        check("rst4_count1", 32'(count), 32'd1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check_reset_state("rst4");
        main_round("rst4_skip", -1, -1, 1);
        check("rst4_skip_p0", 32'(phase), 32'd0);

        // Reset in FLASH with flash still high: reset wins.
        side_req = 1'b1;
        cycle();
        side_req = 1'b0;
        flash = 1'b1;
        cycle();
        check("rstfl_in_flash", 32'(phase), 32'd7);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        flash = 1'b0;
        check_reset_state("rstfl");
        main_round("rstfl_skip", -1, -1, 1);
        check("rstfl_skip_p0", 32'(phase), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
